// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and the sprite engine.
// CPU has priority; a starvation counter lets a long-waiting sprite request win.
module mem_port_arbiter #(
   parameter int ADDR_W       = 22,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_hlt,
   input  logic              i_cpu_re,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_stall,
   input  logic              i_spr_req,
   input  logic [ADDR_W-1:0] i_spr_addr,
   output logic              o_spr_gnt,
   output logic [DATA_W-1:0] o_spr_rdata,
   output logic              o_spr_valid,
   output logic              o_mem_re,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready
);

   typedef enum logic [1:0] {IDLE, CPU_ACC, SPR_ACC} state_t;

   localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_cpu_req;
   logic              w_starved;
   logic              w_cpu_win;
   logic              w_spr_win;
   logic              w_done;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic              r_cpu_done;
   logic              r_mem_re;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_spr_rdata;
   logic              r_spr_gnt;
   logic              r_spr_valid;

   assign w_cpu_req   = (i_cpu_re | i_cpu_we) & ~i_hlt;
   assign w_starved   = (r_starve_cnt >= LP_LIMIT);
   assign w_done      = (r_state != IDLE) & i_mem_ready;
   assign o_cpu_stall = (i_cpu_re | i_cpu_we) & ~r_cpu_done;

   assign o_cpu_rdata = r_cpu_rdata;
   assign o_spr_gnt   = r_spr_gnt;
   assign o_spr_rdata = r_spr_rdata;
   assign o_spr_valid = r_spr_valid;
   assign o_mem_re    = r_mem_re;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // No arbitration in the cpu_done cycle: the pipeline has not advanced yet.
   always_comb begin
      w_state_next = r_state;
      w_cpu_win    = 1'b0;
      w_spr_win    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_cpu_done) begin
               if (i_spr_req && (!w_cpu_req || w_starved)) begin
                  w_spr_win    = 1'b1;
                  w_state_next = SPR_ACC;
               end else if (w_cpu_req) begin
                  w_cpu_win    = 1'b1;
                  w_state_next = CPU_ACC;
               end
            end
         end
         CPU_ACC, SPR_ACC: begin
            if (i_mem_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
         r_cpu_done   <= 1'b0;
         r_mem_re     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_rdata  <= '0;
         r_spr_rdata  <= '0;
         r_spr_gnt    <= 1'b0;
         r_spr_valid  <= 1'b0;
      end else begin
         r_spr_gnt   <= w_spr_win;
         r_spr_valid <= 1'b0;
         r_cpu_done  <= 1'b0;

         if (w_cpu_win) begin
            r_mem_we    <= i_cpu_we;
            r_mem_re    <= i_cpu_re & ~i_cpu_we;
            r_mem_addr  <= i_cpu_addr;
            r_mem_wdata <= i_cpu_wdata;
         end else if (w_spr_win) begin
            r_mem_re   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= i_spr_addr;
         end else if (w_done) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
         end

         if (w_done && r_state == CPU_ACC) begin
            r_cpu_done <= 1'b1;
            if (r_mem_re) r_cpu_rdata <= i_mem_rdata;
         end
         if (w_done && r_state == SPR_ACC) begin
            r_spr_rdata <= i_mem_rdata;
            r_spr_valid <= 1'b1;
         end

         // Counter restarts once the sprite has actually been accepted.
         if (r_spr_gnt)
            r_starve_cnt <= '0;
         else if (i_spr_req && r_state != SPR_ACC && r_starve_cnt != '1)
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

endmodule
